tag_splitter: RTL and testbench
===============================

# tag_splitter

Downstream partner of the flux-merging stage: consumes the single tagged token stream `{tag, data}` from one input FIFO and routes each token's data to the output FIFO selected by its tag, recovering the FLUX independent streams. One registered token slot decouples input reads from output writes. Per-flux token counters and an illegal-tag error counter support debug and verification.

## Interface
- `FLUX`, 2: number of output streams; must be ≥ 2.
- `DATA_WIDTH`, 8: payload width.
- `TAG_WIDTH`, $clog2(FLUX): tag width, derived; not overridden.
- `CNT_WIDTH`, 16: width of each statistics counter.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_empty`  in  1  input FIFO empty.
- `in_read`  out  1  input FIFO pop; `dout` is valid in the same cycle (show-ahead).
- `in_dout`  in  TAG_WIDTH+DATA_WIDTH  input token; tag is in the MSBs.
- `out_full`  in  FLUX  per-stream output FIFO full.
- `out_write`  out  FLUX  per-stream push; one-hot or zero.
- `out_din`  out  DATA_WIDTH  payload, shared by all output FIFOs.
- `tok_cnt`  out  FLUX×CNT_WIDTH  tokens delivered per stream; stream i occupies bits [i*CNT_WIDTH +: CNT_WIDTH].
- `err_cnt`  out  CNT_WIDTH  illegal-tag tokens discarded.
- `err`  out  1  sticky; set by the first illegal tag.

## Operation
- Slot state: `valid`, `tag_q`, `data_q`.
- `drain` = valid & (tag_q ≥ FLUX | !out_full[tag_q]).
- `in_read` = !in_empty & (!valid | drain). This is forced to 0 while `rst` is low.
- On `in_read`, the slot loads `in_dout` and `valid` stays or becomes 1.
- On drain without `in_read`, `valid` is cleared.
- `out_write[i]` = valid & tag_q==i & !out_full[i]. `out_din` = data_q. When `valid`=0, `out_din` is don't-care.
- Legal drain (tag_q < FLUX): `tok_cnt[tag_q]` increments by 1.
- Illegal drain (tag_q ≥ FLUX, only possible when FLUX is not a power of 2):
  - the token is discarded in one cycle;
  - no `out_write` is asserted;
  - `err_cnt` increments;
  - `err` is set.
- Counters wrap modulo 2^CNT_WIDTH. `err` clears only on reset.
- Head-of-line blocking is intended: a token waiting for a full stream blocks all later tokens, which preserves global order.
- Slot states: EMPTY (`valid`=0) and HOLD (`valid`=1).
  - EMPTY→HOLD on `in_read`.
  - HOLD→HOLD on drain&`in_read`, or on a blocked slot.
  - HOLD→EMPTY on drain & !`in_read`.

## Timing
- Reset values: `valid`=0, `tag_q`=0, `data_q`=0, all `tok_cnt`=0, `err_cnt`=0, `err`=0. Hence `out_write`=0 and `in_read`=0 during reset.
- Latency: a token read in cycle N is written in cycle N+1 at the earliest.
- Throughput: 1 token/cycle sustained while the destination is not full.
- Full destination: the slot holds, `in_read`=0, and `out_din` is stable until the write completes.
- A drain and a refill in the same cycle are legal. The counter update comes from the draining token; the slot loads the new token.
- Empty input: no read; the slot drains normally.
- Reset asserted mid-operation: the slot token is lost and the counters clear immediately (asynchronous). No `out_write` appears in the first cycle after reset release.

## Structure
- Package `flux_pkg`:
  - `tag_width(FLUX)` function;
  - parameterized token struct `{tag, data}`;
  - counter typedef.
- Sub-module `token_slot`: a single-entry register with valid, load and drain inputs. It is reusable by the other single-buffered stages.
- Top level: read/route combinational logic, per-flux counter array, error logic.

## Test plan
- Reset release with tokens queued: `in_read`=0 and `out_write`=0 until the first post-reset edge. After it, token {1,0x5A} is read, then `out_write`=2'b10 and `out_din`=0x5A one cycle later.
- Streaming: 8 tokens alternating tags 0/1, outputs never full → 1 write/cycle, data in order, `tok_cnt`={4,4}.
- Backpressure: `out_full[0]`=1 for 5 cycles with the slot holding tag 0 and the next token tagged 1 → `in_read`=0, `out_din` stable, stream 1 not written. Release → tag 0 is written, then tag 1 the next cycle.
- FLUX=3, token tag=3 → no `out_write`, `err_cnt`=1, `err`=1. The following legal token is delivered normally.
- Counter wrap: CNT_WIDTH=4, 17 tokens to stream 0 → `tok_cnt[0]`=1.
- Reset pulse while holding a blocked token → slot cleared and counters 0. After release, no stale write; the next input token is delivered.

Source files
------------

// File: rtl/flux_pkg.sv
// Shared types and helpers for the flux merge/split stages.
// Contents: tag_width() helper, default widths, default token and counter types.
// Stages with non-default widths declare their own token struct from the same layout.
package flux_pkg;

    // Tag bits needed to address flux streams (at least one bit).
    function automatic int unsigned tag_width(input int unsigned flux);
        return (flux < 2) ? 1 : $clog2(flux);
    endfunction

    localparam int unsigned DEF_FLUX       = 2;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_CNT_WIDTH  = 16;
    localparam int unsigned DEF_TAG_WIDTH  = tag_width(DEF_FLUX);

    // Token layout: tag in the MSBs, payload below.
    typedef struct packed {
        logic [DEF_TAG_WIDTH-1:0]  tag;
        logic [DEF_DATA_WIDTH-1:0] data;
    } token_t;

    typedef logic [DEF_CNT_WIDTH-1:0] cnt_t;

endpackage

// File: rtl/tag_splitter_if.sv
// FIFO-side handshake bundle of the tag splitter.
// Input FIFO : in_empty, in_read (show-ahead pop), in_dout {tag, data}.
// Output FIFOs: out_full[FLUX], out_write[FLUX] (one-hot or zero), out_din (shared payload).
// master = splitter side, slave = FIFO side.
interface tag_splitter_if
    import flux_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TAG_WIDTH  = tag_width(FLUX)
);

    logic                          in_empty;
    logic                          in_read;
    logic [TAG_WIDTH+DATA_WIDTH-1:0] in_dout;
    logic [FLUX-1:0]               out_full;
    logic [FLUX-1:0]               out_write;
    logic [DATA_WIDTH-1:0]         out_din;

    modport master (
        input  in_empty,
        input  in_dout,
        input  out_full,
        output in_read,
        output out_write,
        output out_din
    );

    modport slave (
        output in_empty,
        output in_dout,
        output out_full,
        input  in_read,
        input  out_write,
        input  out_din
    );

endinterface

// File: rtl/token_slot.sv
// Single-entry token register shared by the single-buffered flux stages.
// Ports: clk, rst (async active-low), load (capture d), drain (release held token),
//        d (incoming token), valid (slot occupied), q (held token).
// load wins over drain so a drain and a refill can happen in the same cycle.
module token_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } slot_state_t;

    slot_state_t state;

    // Slot occupancy and payload capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= EMPTY;
            q     <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        state <= HOLD;
                        q     <= d;
                    end
                end
                HOLD: begin
                    if (load) begin
                        q <= d;
                    end else if (drain) begin
                        state <= EMPTY;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign valid = (state == HOLD);

endmodule

// File: rtl/tag_splitter.sv
// Routes a tagged token stream from one input FIFO to FLUX output FIFOs by tag.
// Ports: clk, rst (async active-low), bus (FIFO handshakes, master side),
//        tok_cnt (per-stream delivered count, stream i at [i*CNT_WIDTH +: CNT_WIDTH]),
//        err_cnt (illegal-tag tokens discarded), err (sticky illegal-tag flag).
// A token waiting on a full stream blocks everything behind it, keeping global order.
module tag_splitter
    import flux_pkg::*;
#(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    tag_splitter_if.master            bus,
    output logic [FLUX*CNT_WIDTH-1:0] tok_cnt,
    output logic [CNT_WIDTH-1:0]      err_cnt,
    output logic                      err
);

    localparam int unsigned TAG_WIDTH = tag_width(FLUX);
    localparam int unsigned TOK_WIDTH = TAG_WIDTH + DATA_WIDTH;

    typedef struct packed {
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } tok_t;

    tok_t            in_tok;
    tok_t            slot_q;
    logic            valid;
    logic            legal;
    logic            dest_full;
    logic            drain;
    logic            rd;
    logic [FLUX-1:0] wr;

    assign in_tok = tok_t'(bus.in_dout);

    token_slot #(
        .WIDTH (TOK_WIDTH)
    ) u_slot (
        .clk   (clk),
        .rst   (rst),
        .load  (rd),
        .drain (drain),
        .d     (in_tok),
        .valid (valid),
        .q     (slot_q)
    );

    // Illegal tags only exist when FLUX does not fill the tag space.
    generate
        if (FLUX == (32'd1 << TAG_WIDTH)) begin : g_pow2
            assign legal = 1'b1;
        end else begin : g_npow2
            assign legal = (32'(slot_q.tag) < FLUX);
        end
    endgenerate

    // Destination decode: full flag of the addressed stream and its write strobe.
    always_comb begin
        dest_full = 1'b0;
        wr        = '0;
        for (int unsigned i = 0; i < FLUX; i++) begin
            if (slot_q.tag == TAG_WIDTH'(i)) begin
                dest_full = bus.out_full[i];
                wr[i]     = valid & ~bus.out_full[i];
            end
        end
    end

    // Illegal tokens drain unconditionally so they never stall the stream.
    assign drain = valid & (~legal | ~dest_full);
    assign rd    = rst & ~bus.in_empty & (~valid | drain);

    assign bus.in_read   = rd;
    assign bus.out_write = wr;
    assign bus.out_din   = slot_q.data;

    // Statistics: delivered tokens per stream, discarded tokens, sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tok_cnt <= '0;
            err_cnt <= '0;
            err     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < FLUX; i++) begin
                if (wr[i]) begin
                    tok_cnt[i*CNT_WIDTH +: CNT_WIDTH] <= tok_cnt[i*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                end
            end
            if (drain & ~legal) begin
                err_cnt <= err_cnt + CNT_WIDTH'(1);
                err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tag_splitter.sv
// Scoreboard bench for tag_splitter with FLUX=3 (tag 3 is illegal) and 4-bit counters.
module tb_tag_splitter;

    localparam int unsigned FLUX = 3;
    localparam int unsigned DW   = 8;
    localparam int unsigned TW   = 2;
    localparam int unsigned CW   = 4;

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } tok_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [FLUX*CW-1:0] tok_cnt;
    logic [CW-1:0]     err_cnt;
    logic              err;

    tag_splitter_if #(.FLUX(FLUX), .DATA_WIDTH(DW)) bus ();

    tag_splitter #(
        .FLUX       (FLUX),
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .tok_cnt (tok_cnt),
        .err_cnt (err_cnt),
        .err     (err)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    tok_t in_q[$];
    tok_t exp_q[$];
    logic pop_pending;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    task automatic refresh();
        bus.in_empty = (in_q.size() == 0);
        bus.in_dout  = (in_q.size() == 0) ? '0 : in_q[0];
    endtask

    // Queue a token into the input FIFO; legal tags are expected at the outputs in order.
    task automatic put(input logic [TW-1:0] tag, input logic [DW-1:0] data);
        tok_t t;
        t.tag  = tag;
        t.data = data;
        in_q.push_back(t);
        if (32'(tag) < FLUX) exp_q.push_back(t);
        refresh();
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk_tok(input string name, input int e0, input int e1, input int e2);
        chk({name, "_tok0"}, 32'(tok_cnt[0*CW +: CW]), e0);
        chk({name, "_tok1"}, 32'(tok_cnt[1*CW +: CW]), e1);
        chk({name, "_tok2"}, 32'(tok_cnt[2*CW +: CW]), e2);
    endtask

    // Show-ahead input FIFO model: pop after an edge at which in_read was high.
    initial begin
        forever begin
            @(negedge clk);
            pop_pending = bus.in_read;
            @(posedge clk);
            #1;
            if (pop_pending && in_q.size() > 0) begin
                in_q.delete(0);
                refresh();
            end
        end
    end

    // Output monitor: every write must match the head of the expected queue.
    initial begin
        tok_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.out_write != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(bus.out_write), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_onehot", 32'($onehot(bus.out_write)), 1);
                    chk("mon_stream", 32'(bus.out_write), 32'd1 << e.tag);
                    chk("mon_data", 32'(bus.out_din), 32'(e.data));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b0;
        bus.out_full = '0;
        refresh();

        // Reset release with a token already queued.
        put(2'd1, 8'h5A);
        step(2);
        chk("rst_in_read", 32'(bus.in_read), 0);
        chk("rst_out_write", 32'(bus.out_write), 0);
        chk("rst_tok_cnt", 32'(tok_cnt), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;
        #1;
        chk("rel_in_read", 32'(bus.in_read), 1);
        chk("rel_out_write", 32'(bus.out_write), 0);
        step();
        chk("first_write", 32'(bus.out_write), 'b010);
        chk("first_din", 32'(bus.out_din), 'h5A);
        step();
        chk("first_idle", 32'(bus.out_write), 0);
        chk_tok("first", 0, 1, 0);

        // Streaming: 8 tokens alternating tags 0/1, one per cycle.
        for (int i = 0; i < 8; i++) put(TW'(i % 2), DW'(8'h10 + i));
        step(9);
        chk("stream_drained", 32'(exp_q.size()), 0);
        chk_tok("stream", 4, 5, 0);

        // Backpressure on stream 0 with a tag-1 token queued behind.
        bus.out_full = 3'b001;
        put(2'd0, 8'hA1);
        put(2'd1, 8'hB2);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_read", 32'(bus.in_read), 0);
            chk("bp_out_write", 32'(bus.out_write), 0);
            chk("bp_din", 32'(bus.out_din), 'hA1);
            step();
        end
        bus.out_full = 3'b000;
        #1;
        chk("bp_rel_write", 32'(bus.out_write), 'b001);
        chk("bp_rel_in_read", 32'(bus.in_read), 1);
        step();
        chk("bp_next_write", 32'(bus.out_write), 'b010);
        chk("bp_next_din", 32'(bus.out_din), 'hB2);
        step();
        chk("bp_idle", 32'(bus.out_write), 0);
        chk_tok("bp", 5, 6, 0);

        // Illegal tag 3 is discarded, the following legal token goes through.
        put(2'd3, 8'h77);
        put(2'd2, 8'h33);
        step();
        chk("ill_no_write", 32'(bus.out_write), 0);
        chk("ill_refill", 32'(bus.in_read), 1);
        chk("ill_err_before", 32'(err), 0);
        step();
        chk("ill_err_cnt", 32'(err_cnt), 1);
        chk("ill_err", 32'(err), 1);
        chk("ill_next_write", 32'(bus.out_write), 'b100);
        chk("ill_next_din", 32'(bus.out_din), 'h33);
        step();
        chk_tok("ill", 5, 6, 1);
        chk("ill_err_sticky", 32'(err), 1);

        // Reset pulse while a blocked token is held.
        bus.out_full = 3'b010;
        put(2'd1, 8'hC4);
        put(2'd2, 8'hD5);
        step(2);
        chk("blk_out_write", 32'(bus.out_write), 0);
        chk("blk_in_read", 32'(bus.in_read), 0);
        rst = 1'b0;
        #1;
        chk("pulse_tok_cnt", 32'(tok_cnt), 0);
        chk("pulse_err_cnt", 32'(err_cnt), 0);
        chk("pulse_err", 32'(err), 0);
        chk("pulse_in_read", 32'(bus.in_read), 0);
        chk("pulse_out_write", 32'(bus.out_write), 0);
        exp_q.delete(0);
        bus.out_full = 3'b000;
        step();
        rst = 1'b1;
        #1;
        chk("post_rst_no_write", 32'(bus.out_write), 0);
        chk("post_rst_in_read", 32'(bus.in_read), 1);
        step();
        chk("post_rst_write", 32'(bus.out_write), 'b100);
        chk("post_rst_din", 32'(bus.out_din), 'hD5);
        step();
        chk_tok("post_rst", 0, 0, 1);

        // Counter wrap: 17 tokens to stream 0 with 4-bit counters.
        for (int i = 0; i < 17; i++) put(2'd0, DW'(i));
        step(18);
        chk("wrap_drained", 32'(exp_q.size()), 0);
        chk_tok("wrap", 1, 0, 1);

        chk("end_exp_empty", 32'(exp_q.size()), 0);
        chk("end_in_empty", 32'(in_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
